// File: rtl/sa_drain_ctrl.sv
// Systolic-array drain controller: shifts the PE accumulators down into a row buffer,
// then streams them out in original row order over a valid/ready handshake.
module sa_drain_ctrl #(
  parameter int M_ROWS = 4,
  parameter int N_COLS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            load_sum,
  input  logic [N_COLS-1:0][31:0]         col_sum_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_COLS-1:0][31:0]         out_data,
  output logic [$clog2(M_ROWS)-1:0]       out_row,
  output logic                            out_last,
  output logic                            done
);

  localparam int RW = $clog2(M_ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(M_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [RW-1:0]           shift_cnt_r;
  logic [RW-1:0]           emit_cnt_r;
  logic                    done_r;
  logic [N_COLS-1:0][31:0] buf_r [M_ROWS];
  logic [RW-1:0]           cap_row_s;

  // Bottom PE presents row M_ROWS-1 first, so shift k lands in row M_ROWS-1-k.
  assign cap_row_s = LAST_ROW - shift_cnt_r;

  // Drain sequencing, row capture and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      shift_cnt_r <= '0;
      emit_cnt_r  <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= SHIFT;
            shift_cnt_r <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          buf_r[cap_row_s] <= col_sum_in;
          if (shift_cnt_r == LAST_ROW) begin
            state_r     <= EMIT;
            shift_cnt_r <= '0;
            emit_cnt_r  <= '0;
          end else begin
            shift_cnt_r <= shift_cnt_r + RW'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (emit_cnt_r == LAST_ROW) begin
              state_r    <= IDLE;
              emit_cnt_r <= '0;
              done_r     <= 1'b1;
            end else begin
              emit_cnt_r <= emit_cnt_r + RW'(1);
            end
          end else begin
            emit_cnt_r <= emit_cnt_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          shift_cnt_r <= '0;
          emit_cnt_r  <= '0;
        end
      endcase
    end
  end

  // Outputs are decoded straight from registered state so they carry no extra latency.
  assign busy      = (state_r != IDLE);
  assign load_sum  = (state_r == SHIFT);
  assign out_valid = (state_r == EMIT);
  assign out_last  = (state_r == EMIT) && (emit_cnt_r == LAST_ROW);
  assign out_row   = emit_cnt_r;
  assign out_data  = buf_r[emit_cnt_r];
  assign done      = done_r;

endmodule

// File: tb/tb_sa_drain_ctrl.sv
// Self-checking bench for sa_drain_ctrl: a PE-column model feeds the drain port and a
// scoreboard of expected row beats is checked against every valid output cycle.
module tb_sa_drain_ctrl;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int RW = $clog2(M);

  logic                clk;
  logic                reset;
  logic                start;
  logic                busy;
  logic                load_sum;
  logic [N-1:0][31:0]  col_sum_in;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0][31:0]  out_data;
  logic [RW-1:0]       out_row;
  logic                out_last;
  logic                done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0][31:0] data;
    logic [RW-1:0]      row;
  } beat_t;
  beat_t q[$];

  logic [31:0] acc     [M][N];
  logic [31:0] pre_val [M][N];
  logic        preload_en;

  sa_drain_ctrl #(.M_ROWS(M), .N_COLS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .load_sum(load_sum),
    .col_sum_in(col_sum_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE array model: load_sum shifts every accumulator down a row, top row refills with 0.
  always @(posedge clk) begin
    if (preload_en) begin
      acc <= pre_val;
    end else if (load_sum) begin
      for (int r = M - 1; r > 0; r--) acc[r] <= acc[r-1];
      for (int c = 0; c < N; c++) acc[0][c] <= 32'd0;
    end
  end

  always_comb begin
    col_sum_in = '0;
    for (int c = 0; c < N; c++) col_sum_in[c] = acc[M-1][c];
  end

  // Scoreboard monitor: every valid cycle must match the head beat; pop on handshake.
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: out_row=%0d with no beat expected", out_row);
      end else begin
        if (out_data !== q[0].data || out_row !== q[0].row ||
            out_last !== (q[0].row == RW'(M - 1))) begin
          errors++;
          $display("FAIL beat: got row=%0d last=%0b data=%h, want row=%0d last=%0b data=%h",
                   out_row, out_last, out_data, q[0].row, (q[0].row == RW'(M - 1)), q[0].data);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    preload_en = 1'b1;
    tick();
    preload_en = 1'b0;
  endtask

  task automatic push_rows(input bit zero);
    beat_t b;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) b.data[c] = zero ? 32'd0 : pre_val[r][c];
      b.row = RW'(r);
      q.push_back(b);
    end
  endtask

  function automatic bit inr(input int i, input int s, input int lo, input int hi);
    return (s >= 0) && (i - s >= lo) && (i - s <= hi);
  endfunction

  // Cycle-by-cycle control check for a drain whose start edge is at offset 0, plus
  // optionally a second one at offset s2; start is dropped when cycle drop_at is reached.
  task automatic check_window(input string name, input int n, input int s2, input int drop_at);
    logic el, ev, eb, ed;
    for (int i = 1; i <= n; i++) begin
      if (i == drop_at) start = 1'b0;
      el = inr(i, 0, 1, M)     || inr(i, s2, 1, M);
      ev = inr(i, 0, M+1, 2*M) || inr(i, s2, M+1, 2*M);
      eb = inr(i, 0, 1, 2*M)   || inr(i, s2, 1, 2*M);
      ed = inr(i, 0, 2*M+1, 2*M+1) || inr(i, s2, 2*M+1, 2*M+1);
      checks++;
      if (load_sum !== el || out_valid !== ev || busy !== eb || done !== ed) begin
        errors++;
        $display("FAIL %s cycle %0d: load_sum=%0b valid=%0b busy=%0b done=%0b, want %0b %0b %0b %0b",
                 name, i, load_sum, out_valid, busy, done, el, ev, eb, ed);
      end
      tick();
    end
  endtask

  task automatic start_pulse(input bit hold);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    bit bad = 1'b0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        if (acc[r][c] !== 32'd0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_array_zero: array model not all zero after drain, row0col0=%h", name, acc[0][0]);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_beats: %0d expected beats never emitted, want 0 left", name, q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || load_sum !== 1'b0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || done !== 1'b0 || out_row !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%0b load_sum=%0b valid=%0b last=%0b done=%0b row=%0d, want all 0",
               busy, load_sum, out_valid, out_last, done, out_row);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) pre_val[r][c] = 32'(100 * r + c);
    preload();
    push_rows(1'b0);
    out_ready = 1'b1;
    start_pulse(1'b0);
    check_window("basic", 2*M + 2, -1, 0);
    check_drained("basic");
  endtask

  task automatic test_signed_extremes();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) pre_val[r][c] = $urandom;
    pre_val[0][0]     = 32'h8000_0000;
    pre_val[M-1][N-1] = 32'h7FFF_FFFF;
    preload();
    push_rows(1'b0);
    start_pulse(1'b0);
    check_window("signed", 2*M + 2, -1, 0);
    check_drained("signed");
  endtask

  task automatic test_backpressure();
    bit pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int budget = 0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) pre_val[r][c] = 32'(1000 * (r + 1) + 7 * c);
    preload();
    push_rows(1'b0);
    out_ready = 1'b0;
    start_pulse(1'b0);
    while (!out_valid && budget < 20) begin
      tick();
      budget++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_wait: out_valid=%0b after %0d cycles, want 1", out_valid, budget);
      out_ready = 1'b1;
      return;
    end
    for (int j = 0; j < 8; j++) begin
      out_ready = pat[j];
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%0b busy=%0b valid=%0b, want 1 0 0", done, busy, out_valid);
    end
    tick();
    check_drained("bp");
  endtask

  task automatic test_ignored_start();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) pre_val[r][c] = 32'(r * 16 + c + 5);
    preload();
    push_rows(1'b0);
    push_rows(1'b1);
    out_ready = 1'b1;
    start_pulse(1'b1);
    check_window("held_start", 4*M + 3, 2*M + 1, 2*M + 2);
    check_drained("held_start");
  endtask

  task automatic test_reset_mid_shift();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) pre_val[r][c] = 32'(r + 3 * c);
    preload();
    start_pulse(1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (load_sum !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_shift: load_sum=%0b busy=%0b valid=%0b, want 0 0 0", load_sum, busy, out_valid);
    end
    tick();
    preload();
    push_rows(1'b0);
    start_pulse(1'b0);
    check_window("after_rst_shift", 2*M + 2, -1, 0);
    check_drained("after_rst_shift");
  endtask

  task automatic test_reset_mid_emit();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) pre_val[r][c] = 32'(50 + r * 10 + c);
    preload();
    push_rows(1'b0);
    out_ready = 1'b0;
    start_pulse(1'b0);
    for (int i = 0; i < M + 2; i++) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL emit_stall: out_valid=%0b while stalled, want 1", out_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit: out_valid=%0b busy=%0b, want 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL rst_emit_done: done=%0b %0d cycles after reset, want 0", done, i);
      end
      tick();
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    out_ready  = 1'b1;
    preload_en = 1'b0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) pre_val[r][c] = 32'd0;
    test_reset();
    test_basic();
    test_signed_extremes();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_shift();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sa_drain_ctrl.md
SA_DRAIN_CTRL -- requirements
Module: sa_drain_ctrl

Interface
REQ-001 SHALL have parameter M_ROWS, default 4: PE rows per column (drain chain length), >= 2.
REQ-002 SHALL have parameter N_COLS, default 4: PE columns drained in parallel, >= 1.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to drain the array's accumulators.
REQ-006 SHALL have port busy, output, 1: drain in progress.
REQ-007 SHALL have port load_sum, output, 1: broadcast to every PE load_sum; high means accumulators shift down one row.
REQ-008 SHALL have port col_sum_in, input, N_COLS x int32_t: bottom-row PE sum_out per column; index 0 is the left-most column.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a valid row vector.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the row vector.
REQ-011 SHALL have port out_data, output, N_COLS x int32_t: one array row of accumulator results.
REQ-012 SHALL have port out_row, output, $clog2(M_ROWS): original PE row index of out_data.
REQ-013 SHALL have port out_last, output, 1: current beat is row M_ROWS-1.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when the drain completes.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT and EMIT.
REQ-016 IDLE: when start=1 at an edge, the FSM SHALL go to SHIFT and clear the shift counter; start in any other state SHALL be ignored.
REQ-017 SHIFT: load_sum SHALL be 1 for exactly M_ROWS consecutive cycles, with load_sum combinationally equal to (state==SHIFT).
REQ-018 Capture order: on SHIFT cycle k (k=0..M_ROWS-1), col_sum_in SHALL be stored as original row M_ROWS-1-k, because the bottom PE holds row M_ROWS-1 first.
REQ-019 After the M_ROWS-th shift the FSM SHALL go to EMIT; the array is left all-zero because the top-row sum_in is tied to 0.
REQ-020 EMIT: rows SHALL be presented in ascending original order 0..M_ROWS-1, one row per handshake.
REQ-021 A handshake SHALL occur only on an edge with out_valid=1 and out_ready=1; out_data and out_row SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 out_valid SHALL be 1 in every EMIT cycle, including the first, and 0 in all other states.
REQ-023 out_last SHALL equal (state==EMIT && out_row==M_ROWS-1).
REQ-024 On the handshake with out_last=1, the FSM SHALL go to IDLE and done SHALL be 1 in the following cycle only.
REQ-025 busy SHALL be 1 whenever state != IDLE and 0 in the done cycle.
REQ-026 Latency: with start sampled at edge t, load_sum SHALL be high during cycles t+1..t+M_ROWS, and the first out_valid SHALL occur in cycle t+M_ROWS+1.
REQ-027 With out_ready held at 1, the drain SHALL complete with exactly 2*M_ROWS busy cycles and no bubbles.
REQ-028 start=1 in the done cycle (state IDLE) SHALL begin a new drain with no extra idle cycle.
REQ-029 Data SHALL be captured bit-exact as int32, with no saturation, rounding or sign change.
REQ-030 Buffer storage SHALL be M_ROWS x N_COLS x 32 bits; the block SHALL use no other data storage.

Reset
REQ-031 With reset=1 at an edge, in any state, state SHALL become IDLE and the shift and emit counters SHALL become 0.
REQ-032 Reset values: busy=0, load_sum=0, out_valid=0, out_last=0, done=0, out_row=0; buffer contents SHALL be don't-care.
REQ-033 Reset during SHIFT SHALL drop load_sum in the next cycle; a partially drained array is not restored and must be recomputed.
REQ-034 reset SHALL take priority over start.

Verification
REQ-035 Basic drain: M=N=4, array model with PE row r col c = 100*r+c, out_ready=1, start pulse -> load_sum high 4 cycles; beats row0={0,1,2,3} .. row3={300,301,302,303}; out_last on row3; done 1 cycle later; busy 8 cycles.
REQ-036 Signed extremes: row0 col0 = -2147483648, row3 col3 = 2147483647 -> emitted bit-exact; array model reads all zero after the drain.
REQ-037 Backpressure: out_ready pattern 0,0,1,0,1,1,0,1 -> out_data and out_row stable while stalled; exactly 4 beats in order 0..3; no duplicates.
REQ-038 Ignored start: start held high throughout a drain -> only one drain occurs; a second drain begins from the done cycle per REQ-028.
REQ-039 Reset mid-SHIFT: reset asserted on SHIFT cycle 2 -> next cycle load_sum=0, busy=0, out_valid=0; a later start yields a normal 2*M_ROWS drain.
REQ-040 Reset mid-EMIT with out_ready=0 -> out_valid=0 the cycle after reset; no done pulse.
